conv_window_ctrl: RTL and testbench

//  Sequences the line-buffer chain feeding the KSIZE x KSIZE conv window for one frame.

---
 rtl/conv_window_ctrl_if.sv | 30 +++
 rtl/conv_window_ctrl.sv | 171 +++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream / window handshake bundle between the pixel source, the
// conv window controller and the downstream line-buffer chain / PE array.
interface conv_window_ctrl_if #(
    parameter int CW = 9,
    parameter int RW = 9
);
    logic          start;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready;
    logic          win_ready;
    logic          lb_shift;
    logic          lb_clr;
    logic          win_valid;
    logic [CW-1:0] win_col;
    logic [RW-1:0] win_row;
    logic          frame_done;

    // Source / downstream side: arms frames, offers pixels, grants windows
    modport master (
        output start, pix_valid, win_ready,
        input  busy, pix_ready, lb_shift, lb_clr, win_valid, win_col, win_row, frame_done
    );

    // Controller side
    modport slave (
        input  start, pix_valid, win_ready,
        output busy, pix_ready, lb_shift, lb_clr, win_valid, win_col, win_row, frame_done
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// Conv window controller: clears the line-buffer chain, then walks the raster
// pixel stream of one frame, shifting the line buffers on every accepted pixel
// and flagging the cycles where a complete, stride-aligned KSIZE x KSIZE window
// is present at the line-buffer outputs.
module conv_window_ctrl #(
    parameter int IMG_WIDTH  = 482,
    parameter int IMG_HEIGHT = 482,
    parameter int KSIZE      = 3,
    parameter int STRIDE     = 1,
    parameter int CLR_CYCLES = 4,
    parameter int CW         = 9,
    parameter int RW         = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_window_ctrl_if.slave   bus
);
    localparam int OUT_W = (IMG_WIDTH - KSIZE) / STRIDE + 1;
    localparam int OUT_H = (IMG_HEIGHT - KSIZE) / STRIDE + 1;
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);
    localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0]    COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0]    COL_K     = CW'(KSIZE - 1);
    localparam logic [RW-1:0]    ROW_K     = RW'(KSIZE - 1);
    localparam logic [CW-1:0]    WCOL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0]    WROW_LAST = RW'(OUT_H - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);
    localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CLR_W-1:0] clr_cnt;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PH_W-1:0]  col_ph;
    logic [PH_W-1:0]  row_ph;
    logic [CW-1:0]    wc_idx;
    logic [RW-1:0]    wr_idx;
    logic [CW-1:0]    win_col;
    logic [RW-1:0]    win_row;
    logic             win_valid;
    logic             busy;
    logic             pix_ready;
    logic             lb_clr;
    logic             frame_done;
    logic             accept;
    logic             last_pix;
    logic             hit;

    assign accept   = bus.pix_valid & pix_ready;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign hit      = accept && (row >= ROW_K) && (col >= COL_K) &&
                      (col_ph == '0) && (row_ph == '0);

    assign bus.busy       = busy;
    assign bus.pix_ready  = pix_ready;
    assign bus.lb_shift   = accept;
    assign bus.lb_clr     = lb_clr;
    assign bus.win_valid  = win_valid;
    assign bus.win_col    = win_col;
    assign bus.win_row    = win_row;
    assign bus.frame_done = frame_done;

    // State register; reset drops straight back to IDLE from anywhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and state-decoded outputs; pix_ready follows win_ready only while streaming
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        pix_ready  = 1'b0;
        lb_clr     = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                lb_clr = 1'b1;
                if (clr_cnt == CLR_LAST) state_next = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                pix_ready = bus.win_ready;
                if (bus.pix_valid && bus.win_ready && last_pix) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts how long the line buffers have been held in clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + CLR_W'(1);
        else                     clr_cnt <= '0;
    end

    // Raster position and stride phase of the next pixel; phases sit at 0 until the first full window row/col
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (state == CLEAR) begin
            col    <= '0;
            row    <= '0;
            col_ph <= '0;
            row_ph <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col    <= '0;
                col_ph <= '0;
                row    <= row + RW'(1);
                if (row < ROW_K || row_ph == PH_LAST) row_ph <= '0;
                else                                  row_ph <= row_ph + PH_W'(1);
            end else begin
                col <= col + CW'(1);
                if (col < COL_K || col_ph == PH_LAST) col_ph <= '0;
                else                                  col_ph <= col_ph + PH_W'(1);
            end
        end
    end

    // Window flag and output-map coordinates, one cycle behind the accept to match line-buffer read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            wc_idx    <= '0;
            wr_idx    <= '0;
        end else if (state == CLEAR) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
            wc_idx    <= '0;
            wr_idx    <= '0;
        end else begin
            win_valid <= hit;
            if (hit) begin
                win_col <= wc_idx;
                win_row <= wr_idx;
                if (wc_idx == WCOL_LAST) begin
                    wc_idx <= '0;
                    wr_idx <= (wr_idx == WROW_LAST) ? '0 : wr_idx + RW'(1);
                end else begin
                    wc_idx <= wc_idx + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Testbench for conv_window_ctrl: three instances with different image /
// stride geometries, driven frame by frame against a per-cycle reference model.
module tb_conv_window_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   fail_count = 0;

    always #5 clk = ~clk;

    conv_window_ctrl_if #(.CW(9), .RW(9)) bus0 ();
    conv_window_ctrl_if #(.CW(9), .RW(9)) bus1 ();
    conv_window_ctrl_if #(.CW(9), .RW(9)) bus2 ();

    logic       start_v[3];
    logic       pix_valid_v[3];
    logic       win_ready_v[3];
    logic       busy_v[3];
    logic       pix_ready_v[3];
    logic       lb_shift_v[3];
    logic       lb_clr_v[3];
    logic       win_valid_v[3];
    logic       frame_done_v[3];
    logic [8:0] win_col_v[3];
    logic [8:0] win_row_v[3];

    assign bus0.start = start_v[0];
    assign bus0.pix_valid = pix_valid_v[0];
    assign bus0.win_ready = win_ready_v[0];
    assign bus1.start = start_v[1];
    assign bus1.pix_valid = pix_valid_v[1];
    assign bus1.win_ready = win_ready_v[1];
    assign bus2.start = start_v[2];
    assign bus2.pix_valid = pix_valid_v[2];
    assign bus2.win_ready = win_ready_v[2];

    assign busy_v[0] = bus0.busy;
    assign busy_v[1] = bus1.busy;
    assign busy_v[2] = bus2.busy;
    assign pix_ready_v[0] = bus0.pix_ready;
    assign pix_ready_v[1] = bus1.pix_ready;
    assign pix_ready_v[2] = bus2.pix_ready;
    assign lb_shift_v[0] = bus0.lb_shift;
    assign lb_shift_v[1] = bus1.lb_shift;
    assign lb_shift_v[2] = bus2.lb_shift;
    assign lb_clr_v[0] = bus0.lb_clr;
    assign lb_clr_v[1] = bus1.lb_clr;
    assign lb_clr_v[2] = bus2.lb_clr;
    assign win_valid_v[0] = bus0.win_valid;
    assign win_valid_v[1] = bus1.win_valid;
    assign win_valid_v[2] = bus2.win_valid;
    assign frame_done_v[0] = bus0.frame_done;
    assign frame_done_v[1] = bus1.frame_done;
    assign frame_done_v[2] = bus2.frame_done;
    assign win_col_v[0] = bus0.win_col;
    assign win_col_v[1] = bus1.win_col;
    assign win_col_v[2] = bus2.win_col;
    assign win_row_v[0] = bus0.win_row;
    assign win_row_v[1] = bus1.win_row;
    assign win_row_v[2] = bus2.win_row;

    conv_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .KSIZE(3), .STRIDE(1),
                       .CLR_CYCLES(4), .CW(9), .RW(9))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    conv_window_ctrl #(.IMG_WIDTH(7), .IMG_HEIGHT(7), .KSIZE(3), .STRIDE(2),
                       .CLR_CYCLES(4), .CW(9), .RW(9))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    conv_window_ctrl #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .KSIZE(3), .STRIDE(2),
                       .CLR_CYCLES(4), .CW(9), .RW(9))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Arms one frame on instance sel and streams it with pix_valid held high.
    // bp_at/bp_len: drop win_ready for bp_len cycles once bp_at pixels were taken.
    // start_at: pulse start again once start_at pixels were taken.
    // abort_at: pull reset once abort_at pixels were taken.
    task automatic applyStimulus(input int sel, input int w, input int h, input int k,
                                 input int s, input int bp_at, input int bp_len,
                                 input int start_at, input int abort_at,
                                 output int n_acc, output int n_win, output int n_alone);
        int  idx = 0;
        int  bp_cnt = 0;
        int  cyc = 0;
        int  clr_len = 0;
        int  r, c;
        bit  finished = 0;
        bit  start_pulsed = 0;
        bit  bp, acc;
        bit  exp_wv = 0;
        bit  exp_fd = 0;
        int  exp_wc = 0;
        int  exp_wr = 0;
        n_acc = 0;
        n_win = 0;
        n_alone = 0;
        pix_valid_v[sel] = 1'b1;
        win_ready_v[sel] = 1'b1;
        start_v[sel] = 1'b1;
        @(negedge clk);
        #1;
        start_v[sel] = 1'b0;
        #1;
        checkOutput("clr_busy", busy_v[sel], 1);
        while (lb_clr_v[sel] && clr_len < 50) begin
            checkOutput("clr_pix_ready", pix_ready_v[sel], 0);
            clr_len++;
            @(negedge clk);
            #1;
        end
        checkOutput("clr_cycles", clr_len, 4);
        while (!finished && cyc < 2000) begin
            bp = (bp_at >= 0) && (idx == bp_at) && (bp_cnt < bp_len);
            win_ready_v[sel] = bp ? 1'b0 : 1'b1;
            if (start_at >= 0 && idx == start_at && !start_pulsed) begin
                start_v[sel] = 1'b1;
                start_pulsed = 1;
            end else begin
                start_v[sel] = 1'b0;
            end
            #1;
            checkOutput("win_valid", win_valid_v[sel], exp_wv);
            checkOutput("frame_done", frame_done_v[sel], exp_fd);
            if (win_valid_v[sel]) n_win++;
            if (frame_done_v[sel] && !win_valid_v[sel]) n_alone++;
            if (exp_wv) begin
                checkOutput("win_col", win_col_v[sel], exp_wc);
                checkOutput("win_row", win_row_v[sel], exp_wr);
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_busy", busy_v[sel], 0);
                checkOutput("abort_win_valid", win_valid_v[sel], 0);
                checkOutput("abort_pix_ready", pix_ready_v[sel], 0);
                checkOutput("abort_lb_clr", lb_clr_v[sel], 0);
                @(negedge clk);
                #1;
                checkOutput("abort_held_busy", busy_v[sel], 0);
                rst_n = 1'b1;
                start_v[sel] = 1'b0;
                @(negedge clk);
                #1;
                checkOutput("abort_idle_busy", busy_v[sel], 0);
                return;
            end
            if (exp_fd) begin
                checkOutput("done_busy", busy_v[sel], 1);
                checkOutput("done_pix_ready", pix_ready_v[sel], 0);
                finished = 1;
            end else begin
                checkOutput("pix_ready", pix_ready_v[sel], bp ? 0 : 1);
                checkOutput("lb_shift", lb_shift_v[sel], bp ? 0 : 1);
                acc = pix_valid_v[sel] && pix_ready_v[sel];
                if (acc) n_acc++;
                exp_wv = 0;
                exp_fd = 0;
                if (!bp) begin
                    r = idx / w;
                    c = idx % w;
                    exp_wv = (r >= k - 1) && (c >= k - 1) &&
                             ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
                    exp_wc = (c - k + 1) / s;
                    exp_wr = (r - k + 1) / s;
                    exp_fd = (idx == w * h - 1);
                    idx++;
                end else begin
                    bp_cnt++;
                end
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        checkOutput("frame_finished", finished, 1);
        start_v[sel] = 1'b0;
        checkOutput("idle_busy", busy_v[sel], 0);
        checkOutput("idle_frame_done", frame_done_v[sel], 0);
    endtask

    // Bounds the whole run in case the stimulus stalls somewhere
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, win, alone;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            pix_valid_v[i] = 1'b0;
            win_ready_v[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_busy", busy_v[i], 0);
            checkOutput("rst_pix_ready", pix_ready_v[i], 0);
            checkOutput("rst_lb_clr", lb_clr_v[i], 0);
            checkOutput("rst_win_valid", win_valid_v[i], 0);
            checkOutput("rst_frame_done", frame_done_v[i], 0);
            checkOutput("rst_win_col", win_col_v[i], 0);
            checkOutput("rst_win_row", win_row_v[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // 5x4, stride 1, backpressure right after the first window pixel, stray start mid-frame
        applyStimulus(0, 5, 4, 3, 1, 13, 10, 5, -1, acc, win, alone);
        checkOutput("s1_accepts", acc, 20);
        checkOutput("s1_windows", win, 6);
        checkOutput("s1_done_alone", alone, 0);

        // 7x7, stride 2: window grid 3x3
        applyStimulus(1, 7, 7, 3, 2, -1, 0, -1, -1, acc, win, alone);
        checkOutput("s2_accepts", acc, 49);
        checkOutput("s2_windows", win, 9);
        checkOutput("s2_done_alone", alone, 0);

        // 6x6, stride 2: last pixel unaligned so frame_done stands alone
        applyStimulus(2, 6, 6, 3, 2, -1, 0, -1, -1, acc, win, alone);
        checkOutput("s3_accepts", acc, 36);
        checkOutput("s3_windows", win, 4);
        checkOutput("s3_done_alone", alone, 1);

        // Reset while a window is in flight on row 2, then a clean rerun
        applyStimulus(0, 5, 4, 3, 1, -1, 0, -1, 13, acc, win, alone);
        checkOutput("abort_accepts", acc, 13);
        applyStimulus(0, 5, 4, 3, 1, -1, 0, -1, -1, acc, win, alone);
        checkOutput("rerun_accepts", acc, 20);
        checkOutput("rerun_windows", win, 6);
        checkOutput("rerun_done_alone", alone, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
